// File: rtl/riscv_mem_arbiter.sv
// Arbiter sharing one single-ported memory between a hart's fetch (I) and load/store (D)
// requesters: D-priority with an I-starvation guard, one transaction in flight, response timeout.
module riscv_mem_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [XLEN-1:0]   i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [XLEN-1:0]   i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [XLEN-1:0]   d_addr,
  input  logic [XLEN-1:0]   d_wdata,
  input  logic [XLEN/8-1:0] d_be,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [XLEN-1:0]   d_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [XLEN-1:0]   m_addr,
  output logic [XLEN-1:0]   m_wdata,
  output logic [XLEN/8-1:0] m_be,
  input  logic              m_gnt,
  input  logic              m_rvalid,
  input  logic [XLEN-1:0]   m_rdata,
  output logic              err
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);
  localparam logic [TW-1:0] TIMER_MAX  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;   // 1 = D owns the memory, 0 = I
  logic [SW-1:0] streak_q, streak_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          err_q, err_d;

  logic any_req, pick_d, owner_req;

  assign any_req   = i_req | d_req;
  // D wins a tie unless it has already starved a waiting I for STARVE_LIMIT grants
  assign pick_d    = d_req & (~i_req | (streak_q != STREAK_MAX));
  assign owner_req = owner_q ? d_req : i_req;
  assign err       = err_q;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    streak_d = streak_q;
    timer_d  = timer_q;
    err_d    = err_q;
    m_req    = 1'b0;
    m_we     = 1'b0;
    m_addr   = '0;
    m_wdata  = '0;
    m_be     = '0;
    i_gnt    = 1'b0;
    d_gnt    = 1'b0;
    i_rvalid = 1'b0;
    d_rvalid = 1'b0;
    i_rdata  = '0;
    d_rdata  = '0;
    case (state_q)
      S_IDLE: begin
        if (m_rvalid) err_d = 1'b1;
        if (any_req) begin
          owner_d = pick_d;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        m_req = owner_req;
        if (owner_q) begin
          m_we    = d_we;
          m_addr  = d_addr;
          m_wdata = d_wdata;
          m_be    = d_be;
        end else begin
          m_addr  = i_addr;
          m_be    = '1;
        end
        if (m_rvalid) err_d = 1'b1;
        if (!owner_req) begin
          state_d = S_IDLE;
        end else if (m_gnt) begin
          i_gnt   = ~owner_q;
          d_gnt   = owner_q;
          state_d = S_WAIT;
          timer_d = '0;
          if (owner_q && i_req)
            streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + SW'(1);
          else
            streak_d = '0;
        end
      end
      S_WAIT: begin
        timer_d = timer_q + TW'(1);
        if (m_rvalid) begin
          i_rvalid = ~owner_q;
          d_rvalid = owner_q;
          i_rdata  = owner_q ? '0 : m_rdata;
          d_rdata  = owner_q ? m_rdata : '0;
          if (any_req) begin
            owner_d = pick_d;
            state_d = S_ISSUE;
          end else begin
            state_d = S_IDLE;
          end
        end else if (timer_q == TIMER_MAX) begin
          // Abort: complete the owner's handshake with zero data and flag it
          i_rvalid = ~owner_q;
          d_rvalid = owner_q;
          err_d    = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      owner_q  <= 1'b0;
      streak_q <= '0;
      timer_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      streak_q <= streak_d;
      timer_q  <= timer_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench for riscv_mem_arbiter: memory side is driven by hand, one task per scenario.
module tb_riscv_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, i_gnt, i_rvalid;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be, m_be;
  logic        m_req, m_we, m_gnt, m_rvalid, err;
  logic [31:0] m_addr, m_wdata, m_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  riscv_mem_arbiter #(.XLEN(32), .STARVE_LIMIT(4), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .err(err)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;
    m_gnt = 0; m_rvalid = 0; m_rdata = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    i_req = 1; i_addr = 32'h111; d_req = 1; d_we = 1; d_addr = 32'h222; d_wdata = 32'h333;
    d_be = 4'hF; m_gnt = 1; m_rvalid = 1; m_rdata = 32'h444;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if ({m_req, m_we, i_gnt, d_gnt, i_rvalid, d_rvalid, err} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0000000", {m_req, m_we, i_gnt, d_gnt, i_rvalid, d_rvalid, err});
    end
    checks++;
    if ({m_addr, m_wdata, m_be} !== 68'h0) begin
      errors++;
      $display("FAIL reset_payload: got addr=%h wdata=%h be=%h expected 0", m_addr, m_wdata, m_be);
    end
    checks++;
    if ({i_rdata, d_rdata} !== 64'h0) begin
      errors++;
      $display("FAIL reset_rdata: got i=%h d=%h expected 0", i_rdata, d_rdata);
    end
    clear_inputs();
    @(negedge clk) rst_n = 1;
    cyc();
    $display("reset: outputs idle after reset");
  endtask

  task automatic test_single_fetch();
    i_req = 1; i_addr = 32'h100;
    #2;
    checks++;
    if ({m_req, i_gnt} !== 2'b00) begin
      errors++; $display("FAIL fetch_idle: got m_req/i_gnt=%b expected 00", {m_req, i_gnt});
    end
    cyc(); m_gnt = 1; #2;
    checks++;
    if ({m_req, m_we, m_be, m_addr} !== {1'b1, 1'b0, 4'hF, 32'h100}) begin
      errors++;
      $display("FAIL fetch_issue: got req=%b we=%b be=%h addr=%h expected 1 0 f 00000100", m_req, m_we, m_be, m_addr);
    end
    checks++;
    if ({i_gnt, d_gnt} !== 2'b10) begin
      errors++; $display("FAIL fetch_gnt: got i/d=%b expected 10", {i_gnt, d_gnt});
    end
    cyc(); i_req = 0; m_gnt = 0; m_rvalid = 1; m_rdata = 32'hDEADBEEF; #2;
    checks++;
    if ({i_rvalid, i_rdata} !== {1'b1, 32'hDEADBEEF}) begin
      errors++; $display("FAIL fetch_rvalid: got %b %h expected 1 deadbeef", i_rvalid, i_rdata);
    end
    checks++;
    if ({d_rvalid, d_rdata, m_req} !== 34'h0) begin
      errors++; $display("FAIL fetch_d_quiet: got d_rvalid=%b d_rdata=%h m_req=%b expected 0", d_rvalid, d_rdata, m_req);
    end
    cyc(); m_rvalid = 0; m_rdata = 0; #2;
    checks++;
    if ({i_rvalid, m_req} !== 2'b00) begin
      errors++; $display("FAIL fetch_after: got i_rvalid/m_req=%b expected 00", {i_rvalid, m_req});
    end
    $display("fetch: addr=00000100 data=%h", 32'hDEADBEEF);
  endtask

  task automatic test_store();
    d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'h12345678; d_be = 4'h3;
    cyc();
    for (int c = 0; c < 3; c++) begin
      if (c == 2) m_gnt = 1;
      #2;
      checks++;
      if ({m_req, m_we, m_addr, m_wdata, m_be} !== {1'b1, 1'b1, 32'h200, 32'h12345678, 4'h3}) begin
        errors++;
        $display("FAIL store_payload[%0d]: got req=%b we=%b addr=%h wdata=%h be=%h expected 1 1 00000200 12345678 3",
                 c, m_req, m_we, m_addr, m_wdata, m_be);
      end
      checks++;
      if ({d_gnt, i_gnt} !== {(c == 2), 1'b0}) begin
        errors++; $display("FAIL store_gnt[%0d]: got d/i=%b expected %b0", c, {d_gnt, i_gnt}, (c == 2));
      end
      cyc();
    end
    d_req = 0; m_gnt = 0; #2;
    checks++;
    if ({d_rvalid, m_req} !== 2'b00) begin
      errors++; $display("FAIL store_wait: got d_rvalid/m_req=%b expected 00", {d_rvalid, m_req});
    end
    cyc(); m_rvalid = 1; m_rdata = 32'h55; #2;
    checks++;
    if ({d_rvalid, d_rdata, i_rvalid} !== {1'b1, 32'h55, 1'b0}) begin
      errors++; $display("FAIL store_ack: got d_rvalid=%b d_rdata=%h i_rvalid=%b expected 1 00000055 0", d_rvalid, d_rdata, i_rvalid);
    end
    cyc(); m_rvalid = 0; m_rdata = 0;
    $display("store: addr=00000200 wdata=12345678 be=3 acked");
  endtask

  task automatic test_contention();
    logic exp_d;
    i_req = 1; d_req = 1; i_addr = 32'h1000; d_addr = 32'h2000; d_we = 0; d_be = 4'hF;
    cyc();
    for (int n = 0; n < 10; n++) begin
      exp_d = (n % 5) != 4;
      m_gnt = 1; m_rvalid = 0; #2;
      checks++;
      if (m_req !== 1'b1) begin
        errors++; $display("FAIL contend_mreq[%0d]: got %b expected 1", n, m_req);
      end
      checks++;
      if ({d_gnt, i_gnt} !== {exp_d, ~exp_d}) begin
        errors++; $display("FAIL contend_gnt[%0d]: got d/i=%b expected %b%b", n, {d_gnt, i_gnt}, exp_d, ~exp_d);
      end
      checks++;
      if (m_addr !== (exp_d ? 32'h2000 : 32'h1000)) begin
        errors++; $display("FAIL contend_addr[%0d]: got %h expected %h", n, m_addr, exp_d ? 32'h2000 : 32'h1000);
      end
      cyc();
      m_gnt = 0; m_rvalid = 1; m_rdata = n;
      if (n == 9) begin i_req = 0; d_req = 0; end
      #2;
      checks++;
      if ({d_rvalid, i_rvalid} !== {exp_d, ~exp_d}) begin
        errors++; $display("FAIL contend_rvalid[%0d]: got d/i=%b expected %b%b", n, {d_rvalid, i_rvalid}, exp_d, ~exp_d);
      end
      $display("contention: txn %0d granted to %s", n, exp_d ? "D" : "I");
      cyc();
    end
    m_rvalid = 0; m_rdata = 0; #2;
    checks++;
    if ({err, m_req} !== 2'b00) begin
      errors++; $display("FAIL contend_end: got err/m_req=%b expected 00", {err, m_req});
    end
    cyc();
  endtask

  task automatic test_timeout();
    int first_k;
    logic rv64;
    logic [31:0] rd64;
    first_k = 0; rv64 = 0; rd64 = 32'hX;
    m_rdata = 32'hFFFFFFFF;
    d_req = 1; d_we = 0; d_addr = 32'h300; d_be = 4'hF;
    cyc(); m_gnt = 1; #2;
    checks++;
    if (d_gnt !== 1'b1) begin
      errors++; $display("FAIL timeout_gnt: got %b expected 1", d_gnt);
    end
    cyc(); d_req = 0; m_gnt = 0;
    for (int k = 1; k <= 64; k++) begin
      #2;
      if ((d_rvalid || i_rvalid) && first_k == 0) first_k = k;
      if (k == 64) begin rv64 = d_rvalid; rd64 = d_rdata; end
      cyc();
    end
    checks++;
    if (first_k != 64) begin
      errors++; $display("FAIL timeout_cycle: got first rvalid at %0d expected 64", first_k);
    end
    checks++;
    if ({rv64, rd64} !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL timeout_resp: got rvalid=%b rdata=%h expected 1 00000000", rv64, rd64);
    end
    #2;
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL timeout_err: got %b expected 1", err);
    end
    cyc(); m_rvalid = 1; #2;
    checks++;
    if ({i_rvalid, d_rvalid} !== 2'b00) begin
      errors++; $display("FAIL timeout_late: got i/d rvalid=%b expected 00", {i_rvalid, d_rvalid});
    end
    cyc(); m_rvalid = 0; m_rdata = 0; #2;
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL timeout_sticky: got %b expected 1", err);
    end
    cyc();
    $display("timeout: load 00000300 aborted after 64 cycles");
  endtask

  task automatic test_reset_mid_wait();
    i_req = 1; i_addr = 32'h40;
    cyc(); m_gnt = 1;
    cyc(); i_req = 0; m_gnt = 0; #2;
    checks++;
    if (i_rvalid !== 1'b0) begin
      errors++; $display("FAIL rstwait_pending: got %b expected 0", i_rvalid);
    end
    d_addr = 32'h9999; d_req = 1; d_we = 1; d_be = 4'hF;
    rst_n = 0; m_rvalid = 1; m_rdata = 32'hAAAA5555;
    #1;
    checks++;
    if ({m_req, m_we, i_gnt, d_gnt, i_rvalid, d_rvalid, err} !== 7'b0) begin
      errors++;
      $display("FAIL rstwait_ctrl: got %b expected 0000000", {m_req, m_we, i_gnt, d_gnt, i_rvalid, d_rvalid, err});
    end
    checks++;
    if ({m_addr, i_rdata, d_rdata} !== 96'h0) begin
      errors++; $display("FAIL rstwait_data: got addr=%h i=%h d=%h expected 0", m_addr, i_rdata, d_rdata);
    end
    @(negedge clk);
    clear_inputs();
    rst_n = 1;
    cyc();
    i_req = 1; i_addr = 32'h80; #2;
    checks++;
    if (m_req !== 1'b0) begin
      errors++; $display("FAIL rstwait_idle: got m_req=%b expected 0", m_req);
    end
    cyc(); m_gnt = 1; #2;
    checks++;
    if ({i_gnt, m_addr} !== {1'b1, 32'h80}) begin
      errors++; $display("FAIL rstwait_refetch_gnt: got gnt=%b addr=%h expected 1 00000080", i_gnt, m_addr);
    end
    cyc(); i_req = 0; m_gnt = 0; m_rvalid = 1; m_rdata = 32'h0BADF00D; #2;
    checks++;
    if ({i_rvalid, i_rdata} !== {1'b1, 32'h0BADF00D}) begin
      errors++; $display("FAIL rstwait_refetch_data: got %b %h expected 1 0badf00d", i_rvalid, i_rdata);
    end
    cyc(); m_rvalid = 0; m_rdata = 0; #2;
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL rstwait_err: got %b expected 0", err);
    end
    cyc();
    $display("reset mid-wait: refetch addr=00000080 data=0badf00d");
  endtask

  task automatic test_spurious();
    m_rvalid = 1; m_rdata = 32'h77; #2;
    checks++;
    if ({i_rvalid, d_rvalid, i_rdata, d_rdata} !== 66'h0) begin
      errors++; $display("FAIL spurious_rvalid: got i=%b d=%b i_rdata=%h d_rdata=%h expected 0", i_rvalid, d_rvalid, i_rdata, d_rdata);
    end
    cyc(); m_rvalid = 0; m_rdata = 0; #2;
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL spurious_err: got %b expected 1", err);
    end
    cyc();
    $display("spurious: m_rvalid in IDLE flagged");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    clear_inputs();
    test_reset();
    test_single_fetch();
    test_store();
    test_contention();
    test_timeout();
    test_reset_mid_wait();
    test_spurious();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/riscv_mem_arbiter.md
Name: riscv_mem_arbiter

Overview:
- Shares one single-ported memory between the hart's instruction-fetch requester (I) and its load/store requester (D).
- Sequences one transaction at a time: arbitrate, issue, wait for response, route the response back to the owner.
- Gives D priority, with an I-starvation guard and a response timeout.
- Sits between riscv_hart (fetch and data ports) and the memory model or bus bridge.

Parameters:
- XLEN, 32, address/data width.
- STARVE_LIMIT, 4, consecutive D grants with I waiting before I is forced ahead (>=1).
- TIMEOUT, 64, max cycles in WAIT before abort (>=2).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- i_req  in  1  fetch request.
- i_addr  in  XLEN  fetch address.
- i_gnt  out  1  fetch accepted this cycle.
- i_rvalid  out  1  fetch data valid pulse.
- i_rdata  out  XLEN  fetch data.
- d_req  in  1  data request.
- d_we  in  1  1=store, 0=load.
- d_addr  in  XLEN  data address.
- d_wdata  in  XLEN  store data.
- d_be  in  XLEN/8  byte enables.
- d_gnt  out  1  data accepted this cycle.
- d_rvalid  out  1  load data / store ack pulse.
- d_rdata  out  XLEN  load data.
- m_req  out  1  memory request.
- m_we  out  1  memory write.
- m_addr  out  XLEN  memory address.
- m_wdata  out  XLEN  memory write data.
- m_be  out  XLEN/8  memory byte enables.
- m_gnt  in  1  memory accepted the request.
- m_rvalid  in  1  memory response (reads and writes).
- m_rdata  in  XLEN  memory read data.
- err  out  1  sticky protocol/timeout error.

Behaviour:
- Handshake: a requester holds req and its payload stable until gnt. The req&gnt cycle is acceptance. Exactly one rvalid pulse follows each accepted transaction, at least 1 cycle later.
- Reset (rst_n=0, async):
  - State goes to IDLE; owner=I; streak=0; timer=0; err=0.
  - All outputs read 0: m_req, m_we, m_addr, m_wdata, m_be, gnts, rvalids, rdatas.
  - Reset mid-transaction drops the in-flight response; memory is reset with the same rst_n.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE: if any req is high, register the arbitration winner in owner and go to ISSUE. m_req=0.
  - ISSUE:
    - Drive m_req = owner's req.
    - Drive m_we/m_addr/m_wdata/m_be combinationally from the owner. I forces m_we=0 and m_be all-ones; D uses d_we/d_addr/d_wdata/d_be.
    - On m_gnt=1: the owner's gnt = 1 in the same cycle (combinational); go to WAIT; timer=0.
    - If the owner's req drops before gnt: go to IDLE, no error.
  - WAIT:
    - m_req=0; timer increments each cycle.
    - On m_rvalid=1: owner's rvalid=1 and owner's rdata=m_rdata, same cycle. Then re-arbitrate the same cycle: go to ISSUE if any req is high (zero-bubble back-to-back), else IDLE.
    - If timer reaches TIMEOUT-1 without m_rvalid: owner's rvalid=1 with rdata=0, err set, go to IDLE.
  - The non-owner's rvalid is always 0. rdata outputs are 0 whenever their rvalid is 0.
- Arbitration, evaluated only on the IDLE→ISSUE or WAIT→ISSUE transition:
  - Only one req high: that requester wins.
  - Both high: D wins, unless streak==STARVE_LIMIT, in which case I wins.
- streak counter (width $clog2(STARVE_LIMIT+1)):
  - Increments on a D grant while i_req=1, saturating at STARVE_LIMIT.
  - Clears on any I grant, and on a D grant with i_req=0.
- Error cases (all set err, which stays set until reset):
  - m_rvalid in IDLE or ISSUE is ignored.
  - A late response after a timeout is ignored.
  - m_gnt and m_rvalid in the same ISSUE cycle: treat as gnt only; this also sets err.
- Latency: request in IDLE at cycle N gives m_req at N+1 and gnt at N+1 at the earliest. Best-case throughput is one transaction per 2 cycles with a 1-cycle memory.

Test Plan:
- Single fetch: i_req=1, i_addr=0x100; memory gnt at once, rvalid next cycle with 0xDEADBEEF → m_req in cycle 1 with m_addr=0x100, m_we=0, m_be=0xF; i_gnt in cycle 1; i_rvalid in cycle 2 with i_rdata=0xDEADBEEF; d_rvalid=0.
- Store: d_req=1, d_we=1, d_addr=0x200, d_wdata=0x12345678, d_be=0x3; m_gnt delayed 3 cycles → m_req held 3 cycles with stable payload; d_gnt only in the m_gnt cycle; store ack appears on d_rvalid.
- Contention: i_req and d_req held high continuously, STARVE_LIMIT=4 → grant order D,D,D,D,I,D,D,D,D,I…; no idle cycle between transactions.
- Timeout: load accepted, memory never responds, TIMEOUT=64 → d_rvalid=1 with d_rdata=0 exactly 64 cycles after entering WAIT; err=1 and stays set; a later m_rvalid produces no rvalid on either requester.
- Spurious response: m_rvalid=1 while IDLE → no i_rvalid/d_rvalid; err=1.
- Reset mid-WAIT: rst_n=0 during an outstanding fetch → all outputs 0 immediately (async); after release, the FSM is in IDLE and a fresh i_req completes normally.
